// File: rtl/rob_mw.sv
// rob_mw: multi-way reorder buffer.
// Dispatch, retire and completion widths are independent parameters.
// head/tail carry an extra wrap bit, so full and empty can be told apart.
// Completion is addressed by ROB index; a branch squash rolls tail back
// to a checkpoint and invalidates everything younger than it.
module rob_mw #(
   parameter int DEPTH      = 32,
   parameter int DISPATCH_W = 3,
   parameter int RETIRE_W   = 3,
   parameter int CDB_W      = 3,
   parameter int PREG_W     = 6,
   parameter int AREG_W     = 5,
   localparam int IDX_W     = $clog2(DEPTH),
   localparam int PTR_W     = $clog2(DEPTH) + 1,
   localparam int DC_W      = $clog2(DISPATCH_W + 1),
   localparam int RC_W      = $clog2(RETIRE_W + 1)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DC_W-1:0]              disp_count,
   input  logic [DISPATCH_W*AREG_W-1:0] disp_areg,
   input  logic [DISPATCH_W*PREG_W-1:0] disp_t,
   input  logic [DISPATCH_W*PREG_W-1:0] disp_told,
   input  logic [DISPATCH_W-1:0]        disp_has_dest,
   input  logic [DISPATCH_W-1:0]        disp_halt,
   input  logic [CDB_W-1:0]             cdb_valid,
   input  logic [CDB_W*IDX_W-1:0]       cdb_idx,
   input  logic                         br_squash,
   input  logic [PTR_W-1:0]             br_tail,
   output logic [DC_W-1:0]              open_entries,
   output logic [PTR_W-1:0]             out_tail,
   output logic [RC_W-1:0]              retire_count,
   output logic [RETIRE_W*AREG_W-1:0]   retire_areg,
   output logic [RETIRE_W*PREG_W-1:0]   retire_t,
   output logic [RETIRE_W*PREG_W-1:0]   retire_told,
   output logic [RETIRE_W-1:0]          retire_has_dest,
   output logic                         halted
);

   // ---------------------------------------------------------------
   // Architectural state
   // ---------------------------------------------------------------
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic              r_halted;

   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_complete;
   logic [DEPTH-1:0]  r_has_dest;
   logic [DEPTH-1:0]  r_halt;
   logic [AREG_W-1:0] r_areg [DEPTH];
   logic [PREG_W-1:0] r_t    [DEPTH];
   logic [PREG_W-1:0] r_told [DEPTH];

   // ---------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------
   logic [PTR_W-1:0]  w_count;            // occupied entries
   logic [31:0]       w_free;             // free entries after retirement
   logic [PTR_W-1:0]  w_sq_n;             // entries discarded by a squash
   logic [DEPTH-1:0]  w_squash;           // per-entry squash mask
   logic              w_stop;             // retirement scan terminated
   logic              w_halt_ret;         // a halt retires this cycle
   logic [IDX_W-1:0]  w_ridx [RETIRE_W];  // index examined by retire slot i
   logic [IDX_W-1:0]  w_didx [DISPATCH_W];// index written by dispatch slot j

   assign w_count  = r_tail - r_head;
   assign w_sq_n   = r_tail - br_tail;
   assign out_tail = r_tail;
   assign halted   = r_halted;

   // In-order retirement scan from head: stop at the first entry that is
   // not ready, after a halt, or immediately once halted.
   always_comb begin
      retire_count    = '0;
      retire_areg     = '0;
      retire_t        = '0;
      retire_told     = '0;
      retire_has_dest = '0;
      w_halt_ret      = 1'b0;
      w_stop          = r_halted;
      for (int i = 0; i < RETIRE_W; i++) begin
         w_ridx[i] = r_head[IDX_W-1:0] + IDX_W'(i);
         if (!w_stop && r_valid[w_ridx[i]] && r_complete[w_ridx[i]]) begin
            retire_count                       = RC_W'(i + 1);
            retire_areg[i*AREG_W +: AREG_W]    = r_areg[w_ridx[i]];
            retire_t[i*PREG_W +: PREG_W]       = r_t[w_ridx[i]];
            retire_told[i*PREG_W +: PREG_W]    = r_told[w_ridx[i]];
            retire_has_dest[i]                 = r_has_dest[w_ridx[i]];
            if (r_halt[w_ridx[i]]) begin
               w_stop     = 1'b1;
               w_halt_ret = 1'b1;
            end
         end else begin
            w_stop = 1'b1;
         end
      end
   end

   // Dispatch credit: slots freed by this cycle's retirement are reusable now.
   always_comb begin
      w_free = 32'(DEPTH) - 32'(w_count) + 32'(retire_count);
      if (w_free >= 32'(DISPATCH_W))
         open_entries = DC_W'(DISPATCH_W);
      else
         open_entries = DC_W'(w_free);
   end

   // Squash mask: entry k is discarded when its distance from br_tail
   // (mod DEPTH) falls inside the br_tail..old-tail window.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         w_squash[k] = br_squash &&
            (PTR_W'(IDX_W'(IDX_W'(k) - br_tail[IDX_W-1:0])) < w_sq_n);
      end
   end

   // Index each dispatch slot lands on, counted from the current tail.
   always_comb begin
      for (int j = 0; j < DISPATCH_W; j++)
         w_didx[j] = r_tail[IDX_W-1:0] + IDX_W'(j);
   end

   // Pointer, status and entry update. Write order matters: completion,
   // then retire-clear, then squash-clear, then dispatch, so a slot freed
   // by retirement can be refilled in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_halted   <= 1'b0;
         r_valid    <= '0;
         r_complete <= '0;
      end else begin
         r_head <= r_head + PTR_W'(retire_count);
         if (w_halt_ret)
            r_halted <= 1'b1;

         for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && r_valid[cdb_idx[c*IDX_W +: IDX_W]] &&
                !w_squash[cdb_idx[c*IDX_W +: IDX_W]])
               r_complete[cdb_idx[c*IDX_W +: IDX_W]] <= 1'b1;
         end

         for (int i = 0; i < RETIRE_W; i++) begin
            if (RC_W'(i) < retire_count) begin
               r_valid[w_ridx[i]]    <= 1'b0;
               r_complete[w_ridx[i]] <= 1'b0;
            end
         end

         if (br_squash) begin
            r_tail <= br_tail;
            for (int k = 0; k < DEPTH; k++) begin
               if (w_squash[k]) begin
                  r_valid[k]    <= 1'b0;
                  r_complete[k] <= 1'b0;
               end
            end
         end else begin
            r_tail <= r_tail + PTR_W'(disp_count);
            for (int j = 0; j < DISPATCH_W; j++) begin
               if (DC_W'(j) < disp_count) begin
                  r_valid[w_didx[j]]    <= 1'b1;
                  r_complete[w_didx[j]] <= 1'b0;
                  r_has_dest[w_didx[j]] <= disp_has_dest[j];
                  r_halt[w_didx[j]]     <= disp_halt[j];
                  r_areg[w_didx[j]]     <= disp_areg[j*AREG_W +: AREG_W];
                  r_t[w_didx[j]]        <= disp_t[j*PREG_W +: PREG_W];
                  r_told[w_didx[j]]     <= disp_told[j*PREG_W +: PREG_W];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rob_mw.sv
// Bench for rob_mw (default parameters: DEPTH 32, widths 3).
// A queue-based reference model tracks the in-flight instructions in
// program order; a negedge process compares every DUT output to it, and
// directed scenarios add literal spot checks.
module tb_rob_mw;

   logic        clock;
   logic        reset;
   logic [1:0]  disp_count;
   logic [14:0] disp_areg;
   logic [17:0] disp_t;
   logic [17:0] disp_told;
   logic [2:0]  disp_has_dest;
   logic [2:0]  disp_halt;
   logic [2:0]  cdb_valid;
   logic [14:0] cdb_idx;
   logic        br_squash;
   logic [5:0]  br_tail;
   logic [1:0]  open_entries;
   logic [5:0]  out_tail;
   logic [1:0]  retire_count;
   logic [14:0] retire_areg;
   logic [17:0] retire_t;
   logic [17:0] retire_told;
   logic [2:0]  retire_has_dest;
   logic        halted;

   rob_mw dut (
      .clock(clock), .reset(reset),
      .disp_count(disp_count), .disp_areg(disp_areg), .disp_t(disp_t),
      .disp_told(disp_told), .disp_has_dest(disp_has_dest),
      .disp_halt(disp_halt), .cdb_valid(cdb_valid), .cdb_idx(cdb_idx),
      .br_squash(br_squash), .br_tail(br_tail),
      .open_entries(open_entries), .out_tail(out_tail),
      .retire_count(retire_count), .retire_areg(retire_areg),
      .retire_t(retire_t), .retire_told(retire_told),
      .retire_has_dest(retire_has_dest), .halted(halted)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0] areg;
      logic [5:0] t;
      logic [5:0] told;
      bit         hd;
      bit         halt;
      bit         comp;
   } ent_t;

   ent_t q[$];          // in-flight instructions, oldest first
   int   m_head   = 0;  // pointer incl. wrap bit, 0..63
   bit   m_halted = 0;
   bit   m_init   = 0;

   function automatic int m_rc();
      int rc = 0;
      for (int i = 0; i < 3 && i < q.size(); i++) begin
         if (m_halted || !q[i].comp) break;
         rc = i + 1;
         if (q[i].halt) break;
      end
      return rc;
   endfunction

   always @(posedge clock) begin
      int rc, keep, off;
      bit hret;
      ent_t e;
      if (reset) begin
         q.delete();
         m_head   = 0;
         m_halted = 0;
         m_init   = 1;
      end else if (m_init) begin
         rc   = m_rc();
         hret = (rc > 0) && q[rc-1].halt;
         keep = br_squash ? ((int'(br_tail) - m_head + 64) % 64) : q.size();
         for (int c = 0; c < 3; c++) begin
            if (cdb_valid[c]) begin
               off = (int'(cdb_idx[c*5 +: 5]) - (m_head % 32) + 32) % 32;
               if (off < q.size() && off < keep) q[off].comp = 1;
            end
         end
         for (int i = 0; i < rc; i++) void'(q.pop_front());
         m_head = (m_head + rc) % 64;
         keep   = keep - rc;
         if (br_squash) begin
            while (q.size() > keep) void'(q.pop_back());
         end else begin
            for (int j = 0; j < int'(disp_count); j++) begin
               e.areg = disp_areg[j*5 +: 5];
               e.t    = disp_t[j*6 +: 6];
               e.told = disp_told[j*6 +: 6];
               e.hd   = disp_has_dest[j];
               e.halt = disp_halt[j];
               e.comp = 0;
               q.push_back(e);
            end
         end
         if (hret) m_halted = 1;
      end
   end

   // Compare process: outputs depend only on registered state, so they are
   // stable and meaningful at every falling edge once reset has been seen.
   always @(negedge clock) begin
      int rc, fr;
      logic [14:0] ea;
      logic [17:0] et, eo;
      logic [2:0]  eh;
      if (m_init) begin
         rc = m_rc();
         ea = '0; et = '0; eo = '0; eh = '0;
         for (int i = 0; i < rc; i++) begin
            ea[i*5 +: 5] = q[i].areg;
            et[i*6 +: 6] = q[i].t;
            eo[i*6 +: 6] = q[i].told;
            eh[i]        = q[i].hd;
         end
         fr = 32 - q.size() + rc;
         check("retire_count", 64'(retire_count), 64'(rc));
         check("retire_areg", 64'(retire_areg), 64'(ea));
         check("retire_t", 64'(retire_t), 64'(et));
         check("retire_told", 64'(retire_told), 64'(eo));
         check("retire_has_dest", 64'(retire_has_dest), 64'(eh));
         check("open_entries", 64'(open_entries), 64'(fr > 3 ? 3 : fr));
         check("out_tail", 64'(out_tail), 64'((m_head + q.size()) % 64));
         check("halted", 64'(halted), 64'(m_halted));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      disp_count = '0; disp_areg = '0; disp_t = '0; disp_told = '0;
      disp_has_dest = '0; disp_halt = '0;
      cdb_valid = '0; cdb_idx = '0; br_squash = 1'b0; br_tail = '0;
   endtask

   // Field pattern derived from base so retire data is predictable.
   task automatic set_disp(input int n, input int base, input logic [2:0] hmask);
      disp_count = 2'(n);
      disp_areg = '0; disp_t = '0; disp_told = '0; disp_has_dest = '0; disp_halt = '0;
      for (int j = 0; j < n; j++) begin
         disp_areg[j*5 +: 5] = 5'((base + j) % 32);
         disp_t[j*6 +: 6]    = 6'((base + j + 20) % 64);
         disp_told[j*6 +: 6] = 6'((base + j + 40) % 64);
         disp_has_dest[j]    = ((base + j) % 4) != 0;
         disp_halt[j]        = hmask[j];
      end
   endtask

   task automatic set_cdb(input int n, input int a, input int b, input int c);
      cdb_valid = 3'((1 << n) - 1);
      cdb_idx   = {5'(c), 5'(b), 5'(a)};
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   // Completes outstanding entries oldest-first until the model is empty.
   task automatic drain();
      int guard = 0;
      while (q.size() > 0 && guard < 200) begin
         int n;
         int ids[3];
         n = 0;
         ids = '{0, 0, 0};
         for (int o = 0; o < q.size() && n < 3; o++) begin
            if (!q[o].comp) begin
               ids[n] = (m_head + o) % 32;
               n++;
            end
         end
         set_cdb(n, ids[0], ids[1], ids[2]);
         cyc();
         guard++;
      end
      cdb_valid = '0;
      check("drain_done", 64'(q.size()), 64'd0);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      reset = 1'b1;
      idle();
      cyc();
      cyc();
      reset = 1'b0;
      check("rst_open", 64'(open_entries), 64'd3);
      check("rst_tail", 64'(out_tail), 64'd0);
      check("rst_rc", 64'(retire_count), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);

      // Fill: 10 x 3 then 2 reaches exactly DEPTH.
      for (int c = 0; c < 10; c++) begin
         set_disp(3, 3 * c, 3'b000);
         cyc();
      end
      check("fill30_open", 64'(open_entries), 64'd2);
      check("fill30_tail", 64'(out_tail), 64'd30);
      set_disp(2, 30, 3'b000);
      cyc();
      idle();
      check("full_open", 64'(open_entries), 64'd0);
      check("full_tail", 64'(out_tail), 64'd32);
      drain();
      cyc();

      // Out-of-order completion at indices 0..3 (head low bits are 0).
      set_disp(3, 10, 3'b000); cyc();
      set_disp(1, 13, 3'b000); cyc();
      idle();
      set_cdb(3, 1, 2, 3); cyc();
      cdb_valid = '0;
      check("ooo_blocked", 64'(retire_count), 64'd0);
      set_cdb(1, 0, 0, 0); cyc();
      cdb_valid = '0;
      check("ooo_rc3", 64'(retire_count), 64'd3);
      check("ooo_areg3", 64'(retire_areg), 64'd12650);
      cyc();
      check("ooo_rc1", 64'(retire_count), 64'd1);
      check("ooo_areg1", 64'(retire_areg), 64'd13);
      cyc();

      // Move head to 30 with the wrap bit set, then wrap.
      for (int c = 0; c < 8; c++) begin
         set_disp(3, c, 3'b000);
         cyc();
      end
      set_disp(2, 5, 3'b000); cyc();
      idle();
      drain();
      check("pre_wrap_tail", 64'(out_tail), 64'd62);
      set_disp(3, 20, 3'b000); cyc();
      set_disp(1, 23, 3'b000); cyc();
      idle();
      check("wrap_tail", 64'(out_tail), 64'd2);
      set_cdb(3, 30, 31, 0); cyc();
      set_cdb(1, 1, 0, 0);
      check("wrap_rc3", 64'(retire_count), 64'd3);
      cyc();
      cdb_valid = '0;
      check("wrap_rc1", 64'(retire_count), 64'd1);
      cyc();
      check("wrap_rc0", 64'(retire_count), 64'd0);
      check("wrap_open", 64'(open_entries), 64'd3);

      // Squash back to index 4 with a competing dispatch.
      do_reset();
      set_disp(3, 0, 3'b000); cyc();
      set_disp(3, 3, 3'b000); cyc();
      set_disp(3, 6, 3'b000); cyc();
      set_disp(1, 9, 3'b000); cyc();
      set_disp(3, 15, 3'b000);
      br_squash = 1'b1;
      br_tail   = 6'd4;
      set_cdb(1, 5, 0, 0);
      cyc();
      idle();
      check("sq_tail", 64'(out_tail), 64'd4);
      check("sq_open", 64'(open_entries), 64'd3);
      set_cdb(3, 4, 5, 6); cyc();
      set_cdb(3, 7, 8, 9); cyc();
      set_cdb(3, 0, 1, 2); cyc();
      set_cdb(1, 3, 0, 0);
      check("sq_rc3", 64'(retire_count), 64'd3);
      cyc();
      cdb_valid = '0;
      check("sq_rc1", 64'(retire_count), 64'd1);
      cyc();
      check("sq_rc0", 64'(retire_count), 64'd0);
      check("sq_tail_end", 64'(out_tail), 64'd4);

      // Halt at index 1 stops retirement for good.
      do_reset();
      set_disp(3, 0, 3'b010); cyc();
      set_disp(1, 3, 3'b000); cyc();
      idle();
      set_cdb(3, 0, 1, 2); cyc();
      set_cdb(1, 3, 0, 0);
      check("halt_rc2", 64'(retire_count), 64'd2);
      check("halt_pre", 64'(halted), 64'd0);
      cyc();
      cdb_valid = '0;
      check("halt_set", 64'(halted), 64'd1);
      check("halt_rc0", 64'(retire_count), 64'd0);
      set_disp(3, 8, 3'b000); cyc();
      idle();
      set_cdb(3, 4, 5, 6); cyc();
      cdb_valid = '0;
      cyc();
      check("halt_stuck_rc", 64'(retire_count), 64'd0);
      check("halt_tail", 64'(out_tail), 64'd7);

      // Reset with entries still valid.
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("mid_rst_rc", 64'(retire_count), 64'd0);
      check("mid_rst_halted", 64'(halted), 64'd0);
      check("mid_rst_tail", 64'(out_tail), 64'd0);
      check("mid_rst_open", 64'(open_entries), 64'd3);
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
